// File: rtl/weight_dram_responder_pkg.sv
// Shared accelerator definitions: FSM state encoding, default bus widths and
// the deepest supported read-latency pipeline.
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned RD_LAT_MAX = 7;

endpackage

// File: rtl/weight_dram_responder_if.sv
// Read-request / response bus between Accelerator_FSM (master) and the
// weight DRAM responder (slave). RESP_HOLD_EN adds the consumer ready line.
interface weight_dram_responder_if
  import accel_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_len;
  logic              busy;
  logic              req_drop;
  logic [DATA_W-1:0] DRAM_DATA;
  logic              DVAL;
  logic              DLAST;
`ifdef RESP_HOLD_EN
  logic              ready;
`endif

  modport master (
    output rd_req, rd_addr, rd_len,
`ifdef RESP_HOLD_EN
    output ready,
`endif
    input  busy, req_drop, DRAM_DATA, DVAL, DLAST
  );

  modport slave (
    input  rd_req, rd_addr, rd_len,
`ifdef RESP_HOLD_EN
    input  ready,
`endif
    output busy, req_drop, DRAM_DATA, DVAL, DLAST
  );

endinterface

// File: rtl/weight_dram_responder_bram.sv
// Simple dual-port weight store: one write port, one registered read-first
// read port. Deasserting re holds the read register (used for stalls).
module weight_bram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and read in one process so a same-address collision returns old data
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/weight_dram_responder.sv
// Weight DRAM responder: accepts a burst read request and streams rd_len words
// from the on-chip weight store, RD_LAT+2 cycles after acceptance.
// Optional macro RESP_HOLD_EN: adds bus.ready backpressure that stalls the
// whole read pipeline while DVAL=1 and ready=0.
module weight_dram_responder
  import accel_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  weight_dram_responder_if.slave bus,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT = (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  function automatic logic [AW-1:0] wrap(input logic [ADDR_W-1:0] a);
    return AW'(32'(a) % DEPTH);
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              adv;
  logic              issue;
  logic              busy;
  logic              v0_q, l0_q;
  logic [DATA_W-1:0] bram_q;
  logic              tap_v, tap_l;
  logic [DATA_W-1:0] tap_d;
  logic              dval_q, dlast_q, drop_q;
  logic [DATA_W-1:0] data_q;

  assign busy = (state_q != ST_IDLE);

`ifdef RESP_HOLD_EN
  assign adv = !dval_q || bus.ready;
`else
  assign adv = 1'b1;
`endif

  // State and burst counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic: accept, issue one address per advancing cycle, drain
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.rd_req && (bus.rd_len != '0)) begin
          state_d = ST_ISSUE;
          addr_d  = wrap(bus.rd_addr);
          rem_d   = bus.rd_len;
        end
      end
      ST_ISSUE: begin
        if (adv) begin
          issue  = 1'b1;
          addr_d = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (dlast_q && adv) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  weight_bram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_bram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wrap(wr_addr)),
    .wdata (wr_data),
    .re    (issue),
    .raddr (addr_q),
    .rdata (bram_q)
  );

  // Valid/last tags travelling alongside the BRAM read register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0_q <= 1'b0;
      l0_q <= 1'b0;
    end else if (adv) begin
      v0_q <= issue;
      l0_q <= issue && (rem_q == ADDR_W'(1));
    end
  end

  generate
    if (LAT == 0) begin : g_direct
      assign tap_v = v0_q;
      assign tap_l = l0_q;
      assign tap_d = bram_q;
    end else begin : g_delay
      logic [LAT-1:0]    sv, sl;
      logic [DATA_W-1:0] sd [LAT];

      // RD_LAT-deep valid/last/data delay line, frozen on stall
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          sv <= '0;
          sl <= '0;
          for (int unsigned k = 0; k < LAT; k++) begin
            sd[k] <= '0;
          end
        end else if (adv) begin
          sv[0] <= v0_q;
          sl[0] <= l0_q;
          sd[0] <= bram_q;
          for (int unsigned k = 1; k < LAT; k++) begin
            sv[k] <= sv[k-1];
            sl[k] <= sl[k-1];
            sd[k] <= sd[k-1];
          end
        end
      end

      assign tap_v = sv[LAT-1];
      assign tap_l = sl[LAT-1];
      assign tap_d = sd[LAT-1];
    end
  endgenerate

  // Registered response outputs; held while the consumer is not ready
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dval_q  <= 1'b0;
      dlast_q <= 1'b0;
      data_q  <= '0;
    end else if (adv) begin
      dval_q  <= tap_v;
      dlast_q <= tap_v && tap_l;
      data_q  <= tap_v ? tap_d : '0;
    end
  end

  // Flag requests that arrive while a burst is in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= bus.rd_req && busy;
    end
  end

  assign bus.busy      = busy;
  assign bus.req_drop  = drop_q;
  assign bus.DRAM_DATA = data_q;
  assign bus.DVAL      = dval_q;
  assign bus.DLAST     = dlast_q;

endmodule
